// File: rtl/interrupt_ctrl.sv
// Interrupt controller: IF/IE/IME registers, fixed-priority arbitration and a
// vectored req/ack handshake toward the CPU dispatch logic.
module interrupt_ctrl #(
  parameter logic [15:0] IF_ADDR  = 16'hFF0F,
  parameter logic [15:0] IE_ADDR  = 16'hFFFF,
  parameter logic [7:0]  VEC_BASE = 8'h40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  irq_src,
  input  logic [15:0] bus_addr,
  input  logic        bus_wr,
  input  logic        bus_rd,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  input  logic        ime_set,
  input  logic        ime_clr,
  output logic        int_req,
  output logic [7:0]  int_vector,
  input  logic        int_ack,
  output logic        halt_wake
);

  localparam int unsigned NUM_SRC = 5;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t               state_q, state_n;
  logic [NUM_SRC-1:0]   if_q, if_n;
  logic [7:0]           ie_q, ie_n;
  logic                 ime_q, ime_n;
  logic                 req_n;
  logic [7:0]           vec_n;
  logic [7:0]           rdata_n;

  logic [NUM_SRC-1:0]   pending;
  logic [IDX_W-1:0]     win_idx;
  logic [7:0]           win_vec;
  logic                 ack_ok;
  logic [NUM_SRC-1:0]   ack_mask;

  assign pending   = if_q & ie_q[NUM_SRC-1:0];
  assign halt_wake = |pending;
  assign ack_ok    = int_ack && (state_q == ST_PEND);

  // Lowest set pending bit wins; scan downward so the last hit is the lowest.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) win_idx = IDX_W'(i);
    end
    win_vec = VEC_BASE + {2'b00, win_idx, 3'b000};
  end

  // Decode the presented vector back into the IF bit to clear on acceptance.
  always_comb begin
    ack_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int_vector == VEC_BASE + 8'(i * 8)) ack_mask[i] = 1'b1;
    end
  end

  // IF: bus write, then ack clear, then new source pulses (pulses always win).
  always_comb begin
    if_n = if_q;
    if (bus_wr && bus_addr == IF_ADDR) if_n = bus_wdata[NUM_SRC-1:0];
    if (ack_ok) if_n = if_n & ~ack_mask;
    if_n = if_n | irq_src;
  end

  always_comb begin
    ie_n = ie_q;
    if (bus_wr && bus_addr == IE_ADDR) ie_n = bus_wdata;
  end

  always_comb begin
    ime_n = ime_q;
    if (ime_set) ime_n = 1'b1;
    if (ime_clr) ime_n = 1'b0;
    if (ack_ok)  ime_n = 1'b0;
  end

  always_comb begin
    rdata_n = bus_rdata;
    if (bus_rd) begin
      if (bus_addr == IF_ADDR)      rdata_n = {3'b111, if_q};
      else if (bus_addr == IE_ADDR) rdata_n = ie_q;
      else                          rdata_n = 8'hFF;
    end
  end

  // Request FSM; int_req/int_vector are registered alongside the state.
  always_comb begin
    state_n = state_q;
    req_n   = 1'b0;
    vec_n   = 8'h00;
    unique case (state_q)
      ST_IDLE: begin
        if (ime_q && pending != '0) begin
          state_n = ST_PEND;
          req_n   = 1'b1;
          vec_n   = win_vec;
        end
      end
      ST_PEND: begin
        if (int_ack) begin
          state_n = ST_IDLE;
        end else if (!ime_q || pending == '0) begin
          state_n = ST_IDLE;
        end else begin
          req_n = 1'b1;
          vec_n = win_vec;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      if_q       <= '0;
      ie_q       <= '0;
      ime_q      <= 1'b0;
      int_req    <= 1'b0;
      int_vector <= 8'h00;
      bus_rdata  <= 8'h00;
    end else begin
      state_q    <= state_n;
      if_q       <= if_n;
      ie_q       <= ie_n;
      ime_q      <= ime_n;
      int_req    <= req_n;
      int_vector <= vec_n;
      bus_rdata  <= rdata_n;
    end
  end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl with hand-computed expectations.
module tb_interrupt_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  irq_src;
  logic [15:0] bus_addr;
  logic        bus_wr, bus_rd;
  logic [7:0]  bus_wdata, bus_rdata;
  logic        ime_set, ime_clr;
  logic        int_req;
  logic [7:0]  int_vector;
  logic        int_ack;
  logic        halt_wake;

  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0] rd_val;

  interrupt_ctrl dut (
    .clk(clk), .rst(rst), .irq_src(irq_src),
    .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .ime_set(ime_set), .ime_clr(ime_clr),
    .int_req(int_req), .int_vector(int_vector), .int_ack(int_ack),
    .halt_wake(halt_wake)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus_addr = a; bus_wdata = d; bus_wr = 1'b1;
    tick();
    bus_wr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    bus_addr = a; bus_rd = 1'b1;
    tick();
    bus_rd = 1'b0;
    d = bus_rdata;
  endtask

  task automatic pulse_ime_set();
    ime_set = 1'b1; tick(); ime_set = 1'b0;
  endtask

  task automatic pulse_src(input logic [4:0] s);
    irq_src = s; tick(); irq_src = 5'h00;
  endtask

  task automatic ack();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_src = '0; bus_addr = '0; bus_wr = 0; bus_rd = 0;
    bus_wdata = '0; ime_set = 0; ime_clr = 0; int_ack = 0;
    #12;
    check("rst_req", {7'b0, int_req}, 8'h00);
    check("rst_vec", int_vector, 8'h00);
    check("rst_rdata", bus_rdata, 8'h00);
    check("rst_wake", {7'b0, halt_wake}, 8'h00);
    @(posedge clk); #1 rst = 1'b0;

    // 1: timer request, two-cycle latency, ack clears IF[2] and IME
    wr(16'hFFFF, 8'h04);
    pulse_ime_set();
    pulse_src(5'h04);
    check("t1_req_edge1", {7'b0, int_req}, 8'h00);
    tick();
    check("t1_req_edge2", {7'b0, int_req}, 8'h01);
    check("t1_vec", int_vector, 8'h50);
    ack();
    check("t1_req_after_ack", {7'b0, int_req}, 8'h00);
    check("t1_vec_after_ack", int_vector, 8'h00);
    rd(16'hFF0F, rd_val);
    check("t1_if", rd_val, 8'hE0);
    wr(16'hFF0F, 8'h04);
    tick(); tick();
    check("t1_ime_cleared", {7'b0, int_req}, 8'h00);
    check("t1_wake", {7'b0, halt_wake}, 8'h01);
    wr(16'hFF0F, 8'h00);

    // 2: two pending via IF write, serviced in priority order
    wr(16'hFFFF, 8'h1F);
    wr(16'hFF0F, 8'h14);
    pulse_ime_set();
    tick();
    check("t2_req", {7'b0, int_req}, 8'h01);
    check("t2_vec1", int_vector, 8'h50);
    ack();
    check("t2_req_drop", {7'b0, int_req}, 8'h00);
    pulse_ime_set();
    tick();
    check("t2_vec2", int_vector, 8'h60);
    ack();
    rd(16'hFF0F, rd_val);
    check("t2_if_empty", rd_val, 8'hE0);

    // 3: higher-priority source arrives while pending
    pulse_ime_set();
    pulse_src(5'h04);
    tick();
    check("t3_vec_timer", int_vector, 8'h50);
    pulse_src(5'h01);
    tick();
    check("t3_req", {7'b0, int_req}, 8'h01);
    check("t3_vec_vblank", int_vector, 8'h40);
    ack();
    rd(16'hFF0F, rd_val);
    check("t3_if_only_bit0", rd_val, 8'hE4);
    wr(16'hFF0F, 8'h00);

    // 4: same-cycle collisions never lose a pulse
    pulse_ime_set();
    pulse_src(5'h04);
    tick();
    check("t4_vec", int_vector, 8'h50);
    int_ack = 1'b1; irq_src = 5'h04;
    tick();
    int_ack = 1'b0; irq_src = 5'h00;
    check("t4_req_drop", {7'b0, int_req}, 8'h00);
    rd(16'hFF0F, rd_val);
    check("t4_if_kept", rd_val, 8'hE4);
    irq_src = 5'h08;
    wr(16'hFF0F, 8'h00);
    irq_src = 5'h00;
    rd(16'hFF0F, rd_val);
    check("t4_if_wr_vs_src", rd_val, 8'hE8);

    // 5: halt_wake ignores IME; clr beats set
    wr(16'hFF0F, 8'h00);
    wr(16'hFFFF, 8'hE1);
    wr(16'hFF0F, 8'h01);
    check("t5_wake", {7'b0, halt_wake}, 8'h01);
    tick(); tick();
    check("t5_no_req", {7'b0, int_req}, 8'h00);
    ime_set = 1'b1; ime_clr = 1'b1;
    tick();
    ime_set = 1'b0; ime_clr = 1'b0;
    tick(); tick();
    check("t5_clr_wins", {7'b0, int_req}, 8'h00);
    rd(16'hFFFF, rd_val);
    check("t5_ie_8bit", rd_val, 8'hE1);
    rd(16'h1234, rd_val);
    check("t5_other_addr", rd_val, 8'hFF);
    tick();
    check("t5_rdata_hold", bus_rdata, 8'hFF);

    // 6: async reset while pending
    pulse_ime_set();
    tick();
    check("t6_req", {7'b0, int_req}, 8'h01);
    check("t6_vec", int_vector, 8'h40);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_req", {7'b0, int_req}, 8'h00);
    check("t6_rst_vec", int_vector, 8'h00);
    tick();
    rst = 1'b0;
    rd(16'hFF0F, rd_val);
    check("t6_if", rd_val, 8'hE0);
    rd(16'hFFFF, rd_val);
    check("t6_ie", rd_val, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
